// File: rtl/l1c_data_nway.sv
// l1c_data_nway: N-way set-associative L1 data cache between the core data
// port and the wrapper memory port. Write-through, no-write-allocate,
// tree pseudo-LRU replacement, line fill by a burst of single-word reads.
//
// Parameters: SETS (power of 2), WAYS (1, 2 or 4), LINE_WORDS (power of 2).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   core_req/core_write      core access request / store select
//   core_addr/core_in        byte address / lane-aligned store data
//   core_type                access type (byte, half, word, unsigned variants)
//   core_out/core_wait       load data (full word) / busy, 0 on completion
//   D_req/D_addr/D_write     memory request, address, write select
//   D_in/D_type              memory write data, access type
//   D_out/D_wait             memory read data, stall
//
// Optional build macro DC_PERF_CNT_EN adds saturating 32-bit hit/miss
// counters on ports perf_hit and perf_miss.
//
// state  | meaning
// IDLE   | waiting for a core request; request is registered on core_req
// LOOKUP | tag compare on the registered address; load hits complete here
// FILL   | burst-read the line into the victim way, one word per beat
// RESP   | return the requested word from the freshly filled way
// WRITE  | write-through to memory; merge into the line if it was a hit
module l1c_data_nway #(
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_write,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_in,
    input  logic [2:0]  core_type,
    output logic [31:0] core_out,
    output logic        core_wait,
    output logic        D_req,
    output logic [31:0] D_addr,
    output logic        D_write,
    output logic [31:0] D_in,
    output logic [2:0]  D_type,
    input  logic [31:0] D_out,
    input  logic        D_wait
`ifdef DC_PERF_CNT_EN
    ,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
`endif
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, RESP, WRITE} state_t;

    state_t              state;
    logic [31:0]         req_addr;
    logic [31:0]         req_data;
    logic [2:0]          req_type;
    logic                req_write;
    logic [WORD_W-1:0]   cnt;
    logic                hit_q;
    logic [WAY_W-1:0]    way_q;

    logic [WAYS-1:0]     valid    [SETS];
    logic [PLRU_W-1:0]   plru     [SETS];
    logic [TAG_W-1:0]    tag_mem  [SETS][WAYS];
    logic [31:0]         data_mem [SETS][WAYS][LINE_WORDS];

    logic [TAG_W-1:0]    r_tag;
    logic [IDX_W-1:0]    r_idx;
    logic [WORD_W-1:0]   r_word;
    logic [WAYS-1:0]     match;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    victim;
    logic [3:0]          byte_mask;
    logic                fill_last;

    assign r_tag     = req_addr[31:IDX_W+OFF_W];
    assign r_idx     = req_addr[IDX_W+OFF_W-1:OFF_W];
    assign r_word    = req_addr[OFF_W-1:2];
    assign fill_last = (cnt == WORD_W'(LINE_WORDS - 1));

    // Tree bits: t[0] is the root (0 = victim in ways 0/1, 1 = ways 2/3);
    // t[1] and t[2] pick within the left and right pair. With two ways only
    // t[0] exists and directly names the victim.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] b);
        logic [2:0] t;
        logic [1:0] v;
        t = 3'(b);
        v = 2'b00;
        if (WAYS == 2)
            v = {1'b0, t[0]};
        else if (WAYS == 4)
            v = {t[0], t[0] ? t[2] : t[1]};
        return WAY_W'(v);
    endfunction

    // Point every node on the path of the used way towards the other side.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] b,
                                                     input logic [WAY_W-1:0]  way);
        logic [2:0] t;
        logic [1:0] w;
        t = 3'(b);
        w = 2'(way);
        if (WAYS == 2) begin
            t[0] = ~w[0];
        end else if (WAYS == 4) begin
            t[0] = ~w[1];
            if (w[1])
                t[2] = ~w[0];
            else
                t[1] = ~w[0];
        end
        return PLRU_W'(t);
    endfunction

    always_comb begin
        match   = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            match[w] = valid[r_idx][w] && (tag_mem[r_idx][w] == r_tag);
        hit = $onehot(match);
        for (int w = WAYS - 1; w >= 0; w--)
            if (match[w]) hit_way = WAY_W'(w);
    end

    // Lowest-index invalid way wins over the PLRU choice.
    always_comb begin
        victim = plru_victim(plru[r_idx]);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[r_idx][w]) victim = WAY_W'(w);
    end

    always_comb begin
        case (req_type)
            3'b000, 3'b100: byte_mask = 4'b0001 << req_addr[1:0];
            3'b001, 3'b101: byte_mask = 4'b0011 << {req_addr[1], 1'b0};
            3'b010:         byte_mask = 4'hF;
            default:        byte_mask = 4'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_data  <= '0;
            req_type  <= '0;
            req_write <= 1'b0;
            cnt       <= '0;
            hit_q     <= 1'b0;
            way_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                plru[s]  <= '0;
            end
`ifdef DC_PERF_CNT_EN
            perf_hit  <= '0;
            perf_miss <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (core_req) begin
                        req_addr  <= core_addr;
                        req_data  <= core_in;
                        req_type  <= core_type;
                        req_write <= core_write;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
`ifdef DC_PERF_CNT_EN
                    if (hit) begin
                        if (perf_hit != '1) perf_hit <= perf_hit + 32'd1;
                    end else begin
                        if (perf_miss != '1) perf_miss <= perf_miss + 32'd1;
                    end
`endif
                    if (req_write) begin
                        hit_q <= hit;
                        way_q <= hit_way;
                        state <= WRITE;
                    end else if (hit) begin
                        plru[r_idx] <= plru_touch(plru[r_idx], hit_way);
                        state       <= IDLE;
                    end else begin
                        way_q                <= victim;
                        valid[r_idx][victim] <= 1'b0;
                        cnt                  <= '0;
                        state                <= FILL;
                    end
                end
                FILL: begin
                    if (!D_wait) begin
                        if (fill_last) begin
                            valid[r_idx][way_q] <= 1'b1;
                            plru[r_idx]         <= plru_touch(plru[r_idx], way_q);
                            cnt                 <= '0;
                            state               <= RESP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESP: state <= IDLE;
                WRITE: begin
                    if (!D_wait) begin
                        if (hit_q) plru[r_idx] <= plru_touch(plru[r_idx], way_q);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays need no reset: nothing is read from a way until its
    // valid bit is set by a complete fill.
    always_ff @(posedge clk) begin
        if (state == FILL && !D_wait) begin
            data_mem[r_idx][way_q][cnt] <= D_out;
            if (fill_last) tag_mem[r_idx][way_q] <= r_tag;
        end
        if (state == WRITE && !D_wait && hit_q) begin
            for (int b = 0; b < 4; b++)
                if (byte_mask[b])
                    data_mem[r_idx][way_q][r_word][8*b +: 8] <= req_data[8*b +: 8];
        end
    end

    always_comb begin
        core_out  = '0;
        core_wait = 1'b0;
        D_req     = 1'b0;
        D_addr    = '0;
        D_write   = 1'b0;
        D_in      = '0;
        D_type    = '0;
        case (state)
            IDLE: core_wait = core_req;
            LOOKUP: begin
                if (!req_write && hit)
                    core_out = data_mem[r_idx][hit_way][r_word];
                else
                    core_wait = 1'b1;
            end
            FILL: begin
                core_wait = 1'b1;
                D_req     = 1'b1;
                D_type    = 3'b010;
                D_addr    = {req_addr[31:OFF_W], cnt, 2'b00};
            end
            RESP: core_out = data_mem[r_idx][way_q][r_word];
            WRITE: begin
                core_wait = D_wait;
                D_req     = 1'b1;
                D_write   = 1'b1;
                D_addr    = req_addr;
                D_in      = req_data;
                D_type    = req_type;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1c_data_nway.sv
// Randomized scoreboard bench for l1c_data_nway (default parameters).
// The reference model tracks which lines are cached per set by last-use time
// (least recently used line is evicted) and keeps the external memory as a
// sparse word array whose untouched words read back as their own address.
module tb_l1c_data_nway;

    localparam int SETS = 64;
    localparam int WAYS = 2;
    localparam int LW   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_write;
    logic [31:0] core_addr, core_in;
    logic [2:0]  core_type;
    logic [31:0] core_out;
    logic        core_wait;
    logic        D_req, D_write;
    logic [31:0] D_addr, D_in, D_out;
    logic [2:0]  D_type;
    logic        D_wait;
`ifdef DC_PERF_CNT_EN
    logic [31:0] perf_hit, perf_miss;
`endif

    l1c_data_nway #(.SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_write(core_write), .core_addr(core_addr),
        .core_in(core_in), .core_type(core_type), .core_out(core_out),
        .core_wait(core_wait),
        .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in),
        .D_type(D_type), .D_out(D_out), .D_wait(D_wait)
`ifdef DC_PERF_CNT_EN
        , .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
        int          beats;
    } core_exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  typ;
    } mem_exp_t;

    core_exp_t   core_q[$];
    mem_exp_t    mem_q[$];
    int unsigned mem[int unsigned];
    int unsigned cached[int unsigned];
    int unsigned now_t = 0;
    int          rd_beats = 0;
    int          beats_mark = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic void chk(string name, logic [69:0] act, logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        int unsigned k;
        k = {a[31:2], 2'b00};
        if (mem.exists(k)) return mem[k];
        return k;
    endfunction

    function automatic logic [3:0] lane_mask(logic [2:0] t, logic [1:0] lo);
        case (t)
            3'b000, 3'b100: return 4'b0001 << lo;
            3'b001, 3'b101: return lo[1] ? 4'b1100 : 4'b0011;
            3'b010:         return 4'hF;
            default:        return 4'h0;
        endcase
    endfunction

    function automatic void model_fill(int unsigned line);
        int          n = 0;
        int unsigned vk = 0;
        int unsigned best = 32'hFFFF_FFFF;
        foreach (cached[k]) begin
            if ((k % SETS) == (line % SETS)) begin
                n++;
                if (cached[k] < best) begin
                    best = cached[k];
                    vk   = k;
                end
            end
        end
        if (n >= WAYS) cached.delete(vk);
        now_t++;
        cached[line] = now_t;
    endfunction

    // Issue one core access; called at posedge+1 and returns at posedge+1.
    task automatic access(input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] typ);
        int unsigned line;
        bit          hit;
        core_exp_t   e;
        mem_exp_t    m;
        int          exp_waits, nw;
        bit          done;
        line      = addr >> 4;
        hit       = cached.exists(line);
        e.is_load = !wr;
        e.data    = wr ? 32'h0 : mem_rd(addr);
        e.beats   = (!wr && !hit) ? LW : 0;
        if (!wr) begin
            if (hit) begin
                now_t++;
                cached[line] = now_t;
                exp_waits = 1;
            end else begin
                model_fill(line);
                for (int i = 0; i < LW; i++) begin
                    m.wr = 1'b0; m.addr = {addr[31:4], 4'(i * 4)};
                    m.data = 32'h0; m.typ = 3'b010;
                    mem_q.push_back(m);
                end
                exp_waits = 2 + 3 * LW;
            end
        end else begin
            if (hit) begin
                now_t++;
                cached[line] = now_t;
            end
            m.wr = 1'b1; m.addr = addr; m.data = data; m.typ = typ;
            mem_q.push_back(m);
            exp_waits = 4;
        end
        core_q.push_back(e);
        core_req = 1'b1; core_write = wr; core_addr = addr;
        core_in = data; core_type = typ;
        nw = 0; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!core_wait) done = 1'b1;
            else nw++;
        end
        chk("completion_timeout", 70'(done), 70'(1));
        chk("busy_cycles", 70'(nw), 70'(exp_waits));
        @(posedge clk); #1;
        core_req = 1'b0;
    endtask

    task automatic check_all_zero(string name);
        chk(name, {core_wait, core_out, D_req, D_write, D_type},
            70'(0));
        chk({name, "_d"}, {D_addr, D_in}, 70'(0));
    endtask

    // Memory: two stall cycles, then accept.
    initial begin
        int wcnt = 0;
        D_wait = 1'b0;
        D_out  = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                wcnt = 0; D_wait = 1'b0;
            end else if (D_req) begin
                if (wcnt < 2) begin
                    D_wait = 1'b1; wcnt++;
                end else begin
                    D_wait = 1'b0; wcnt = 0;
                    D_out  = D_write ? 32'h0 : mem_rd(D_addr);
                end
            end else begin
                D_wait = 1'b0;
            end
        end
    end

    // Memory-side monitor: transaction order/content and stall stability.
    initial begin
        logic [69:0] prev = '0;
        bit          stalled = 1'b0;
        mem_exp_t    m;
        logic [3:0]  mk;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (!rst && D_req) begin
                if (!D_wait) begin
                    if (mem_q.size() == 0) begin
                        chk("unexpected_mem_beat", {D_write, D_addr}, 70'h3F_FFFF_FFFF);
                    end else begin
                        m = mem_q.pop_front();
                        if (m.wr)
                            chk("mem_write", {D_write, D_addr, D_type, D_in},
                                {1'b1, m.addr, m.typ, m.data});
                        else
                            chk("mem_read", {D_write, D_addr, D_type, D_in},
                                {1'b0, m.addr, 3'b010, 32'h0});
                        if (D_write) begin
                            mk = lane_mask(D_type, D_addr[1:0]);
                            w  = mem_rd(D_addr);
                            for (int b = 0; b < 4; b++)
                                if (mk[b]) w[8*b +: 8] = D_in[8*b +: 8];
                            mem[{D_addr[31:2], 2'b00}] = w;
                        end else begin
                            rd_beats++;
                        end
                    end
                    stalled = 1'b0;
                end else begin
                    if (stalled)
                        chk("stall_stable", {D_write, D_addr, D_type, D_in}, prev);
                    prev    = {D_write, D_addr, D_type, D_in};
                    stalled = 1'b1;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Core-side monitor: pops the scoreboard on every completion cycle.
    initial begin
        core_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && core_req && !core_wait) begin
                if (core_q.size() == 0) begin
                    chk("unexpected_completion", 70'(core_out), 70'h3F_FFFF_FFFF);
                end else begin
                    e = core_q.pop_front();
                    if (e.is_load) chk("load_data", 70'(core_out), 70'(e.data));
                    chk("fill_beats", 70'(rd_beats - beats_mark), 70'(e.beats));
                    beats_mark = rd_beats;
                end
            end
        end
    end

    initial begin
        logic [31:0] a, d;
        logic [2:0]  t;
        logic [1:0]  lo;
        int          start;
        bit          ok;
        mem_exp_t    m;
        rst = 1'b1; core_req = 1'b0; core_write = 1'b0;
        core_addr = '0; core_in = '0; core_type = '0;
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("reset_outputs");
        rst = 1'b0;
        @(posedge clk); #1;

        access(1'b0, 32'h0000_1008, 32'h0, 3'b010);
        access(1'b0, 32'h0000_1008, 32'h0, 3'b010);
`ifdef DC_PERF_CNT_EN
        chk("perf_counts", {perf_hit, perf_miss}, {32'd1, 32'd1});
`endif

        access(1'b0, 32'h0000_1000, 32'h0, 3'b010);
        access(1'b0, 32'h0000_2000, 32'h0, 3'b010);
        access(1'b0, 32'h0000_1000, 32'h0, 3'b010);
        access(1'b0, 32'h0000_3000, 32'h0, 3'b010);
        access(1'b0, 32'h0000_1000, 32'h0, 3'b010);
        access(1'b0, 32'h0000_2000, 32'h0, 3'b010);

        access(1'b1, 32'h0000_1001, 32'h0000_AB00, 3'b000);
        access(1'b0, 32'h0000_1000, 32'h0, 3'b010);

        access(1'b1, 32'h0000_5000, 32'hDEAD_BEEF, 3'b010);
        access(1'b0, 32'h0000_5000, 32'h0, 3'b010);

        // Reset during the third fill beat of a cold line.
        for (int i = 0; i < LW; i++) begin
            m.wr = 1'b0; m.addr = 32'h0000_7000 + 32'(i * 4);
            m.data = 32'h0; m.typ = 3'b010;
            mem_q.push_back(m);
        end
        start = rd_beats;
        core_req = 1'b1; core_write = 1'b0; core_addr = 32'h0000_7000;
        core_in = 32'h0; core_type = 3'b010;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (rd_beats == start + 2) ok = 1'b1;
        end
        chk("two_beats_before_reset", 70'(ok), 70'(1));
        @(posedge clk); #2;
        rst = 1'b1; core_req = 1'b0;
        #1;
        check_all_zero("midfill_reset_outputs");
        mem_q.delete(); core_q.delete(); cached.delete();
        beats_mark = rd_beats;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 32'h0000_7000, 32'h0, 3'b010);

        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4)
              | ($urandom_range(0, 3) << 2);
            lo = 2'($urandom_range(0, 3));
            d  = $urandom;
            if ($urandom_range(0, 9) < 4) begin
                case ($urandom_range(0, 2))
                    0: begin t = 3'b000; a[1:0] = lo; d = (d & 32'hFF) << (8 * lo); end
                    1: begin t = 3'b001; a[1:0] = {lo[1], 1'b0}; d = (d & 32'hFFFF) << (16 * lo[1]); end
                    default: begin t = 3'b010; a[1:0] = 2'b00; end
                endcase
                access(1'b1, a, d, t);
            end else begin
                a[1:0] = lo;
                case ($urandom_range(0, 4))
                    0: t = 3'b000;
                    1: t = 3'b001;
                    2: t = 3'b010;
                    3: t = 3'b100;
                    default: t = 3'b101;
                endcase
                access(1'b0, a, 32'h0, t);
            end
        end

        repeat (3) @(posedge clk);
        chk("queues_drained", 70'(mem_q.size() + core_q.size()), 70'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
